// File: rtl/period_meter_v.sv
// Period / duty-cycle meter for a slow signal asynchronous to clk.
// Measures the last complete period of sig_in plus its high and low parts,
// and flags a stall when no edge arrives within TIMEOUT clk cycles.
module period_meter_v #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       rst_pipe;
    logic             rst_n;
    logic             sync_q1;
    logic             sync_q2;
    logic             dly_q;
    logic             rise;
    logic             fall;
    logic             any_edge;
    logic             at_limit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_tmp;
    logic             load_meas;
    logic             cap_hi;
    logic             set_stall;
    logic             clr_stall;

    // Reset: assert asynchronously, release on a clk edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // Two-flop synchronizer plus delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync_q1 <= sig_in;
            sync_q2 <= sync_q1;
            dly_q   <= sync_q2;
        end
    end

    assign rise     = sync_q2 & ~dly_q;
    assign fall     = ~sync_q2 & dly_q;
    assign any_edge = rise | fall;
    assign at_limit = (cnt == CNT_LIMIT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; an edge always beats the timeout
    always_comb begin
        state_next = state;
        load_meas  = 1'b0;
        cap_hi     = 1'b0;
        set_stall  = 1'b0;
        clr_stall  = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_next = MEAS_HIGH;
                        clr_stall  = 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        cap_hi     = 1'b1;
                        state_next = MEAS_LOW;
                    end else if (at_limit && !any_edge) begin
                        set_stall  = 1'b1;
                        state_next = IDLE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        load_meas  = 1'b1;
                        state_next = MEAS_HIGH;
                    end else if (at_limit && !any_edge) begin
                        set_stall  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Duration counter: restarts at 1 on every rise, saturates at TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (!at_limit) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Measurement capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_tmp     <= '0;
            period     <= '0;
            high_time  <= '0;
            low_time   <= '0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= load_meas;
            if (cap_hi) begin
                hi_tmp <= cnt;
            end
            if (load_meas) begin
                period    <= cnt;
                high_time <= hi_tmp;
                low_time  <= cnt - hi_tmp;
            end
            if (set_stall) begin
                stalled <= 1'b1;
            end else if (clr_stall) begin
                stalled <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter_v.sv
// Self-checking bench for period_meter_v with a timestamp-based reference model.
module tb_period_meter_v;

    localparam int unsigned CNT_W = 16;
    localparam int          TMO   = 100;
    localparam int unsigned OBS_W = 3 * CNT_W + 2;

    logic             clk;
    logic             reset_n;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic             meas_valid;
    logic             stalled;

    int checks;
    int errors;

    // Reference model: edges seen three clk edges after sig_in changes,
    // durations derived from the clk index of the last detected rise.
    int               cyc;
    int               last_rise;
    int               phase;       // 0 idle, 1 timing high part, 2 timing low part
    int               m_hi;
    logic [3:0]       sh;
    logic [CNT_W-1:0] m_period;
    logic [CNT_W-1:0] m_high;
    logic [CNT_W-1:0] m_low;
    logic             m_valid;
    logic             m_stalled;

    period_meter_v #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .low_time  (low_time),
        .meas_valid(meas_valid),
        .stalled   (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OBS_W-1:0] obs();
        return {meas_valid, stalled, period, high_time, low_time};
    endfunction

    function automatic logic [OBS_W-1:0] mdl();
        return {m_valid, m_stalled, m_period, m_high, m_low};
    endfunction

    task automatic model_reset();
        phase     = 0;
        m_hi      = 0;
        sh        = 4'b0000;
        last_rise = cyc;
        m_period  = '0;
        m_high    = '0;
        m_low     = '0;
        m_valid   = 1'b0;
        m_stalled = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic s);
        int   elapsed;
        logic r;
        logic f;
        cyc++;
        sh      = {sh[2:0], s};
        r       = sh[2] & ~sh[3];
        f       = ~sh[2] & sh[3];
        elapsed = cyc - last_rise;
        if (elapsed > TMO) elapsed = TMO;
        m_valid = 1'b0;
        if (!e) begin
            phase = 0;
        end else if (phase == 0) begin
            if (r) begin
                phase     = 1;
                m_stalled = 1'b0;
            end
        end else if (phase == 1) begin
            if (f) begin
                m_hi  = elapsed;
                phase = 2;
            end else if (elapsed == TMO && !r) begin
                m_stalled = 1'b1;
                phase     = 0;
            end
        end else begin
            if (r) begin
                m_period = CNT_W'(elapsed);
                m_high   = CNT_W'(m_hi);
                m_low    = CNT_W'(elapsed - m_hi);
                m_valid  = 1'b1;
                phase    = 1;
            end else if (elapsed == TMO && !f) begin
                m_stalled = 1'b1;
                phase     = 0;
            end
        end
        if (r) last_rise = cyc;
    endtask

    // Drive one clk cycle of stimulus and advance the model
    task automatic drive_cycle(input logic e, input logic s);
        @(negedge clk);
        en     = e;
        sig_in = s;
        @(posedge clk);
        #1;
        model_step(e, s);
    endtask

    task automatic idle_prefix();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (period !== '0 || high_time !== '0 || low_time !== '0) begin
            errors++;
            $display("FAIL reset_outputs got p=%0d h=%0d l=%0d exp 0 0 0", period, high_time, low_time);
        end
        checks++;
        if (meas_valid !== 1'b0 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b s=%b exp 0 0", meas_valid, stalled);
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0);
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL reset_release cyc=%0d {v,st,p,h,l} got=%h exp=%h", cyc, obs(), mdl());
            end
        end
    endtask

    task automatic test_pattern_3_2();
        int nvalid = 0;
        int last_v = -1;
        idle_prefix();
        for (int k = 0; k < 40; k++) begin
            drive_cycle(1'b1, (k % 5) < 3);
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL pattern_3_2 cyc=%0d {v,st,p,h,l} got=%h exp=%h", cyc, obs(), mdl());
            end
            if (meas_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (period !== CNT_W'(5) || high_time !== CNT_W'(3) || low_time !== CNT_W'(2)) begin
                    errors++;
                    $display("FAIL pattern_values got p=%0d h=%0d l=%0d exp 5 3 2", period, high_time, low_time);
                end
                if (last_v >= 0) begin
                    checks++;
                    if (cyc - last_v != 5) begin
                        errors++;
                        $display("FAIL pattern_spacing got %0d exp 5", cyc - last_v);
                    end
                end
                last_v = cyc;
            end
        end
        checks++;
        if (nvalid != 7) begin
            errors++;
            $display("FAIL pattern_count got %0d exp 7", nvalid);
        end
    endtask

    // 50/50 square wave: period equals TIMEOUT, so every rise lands on the limit
    task automatic test_square_50();
        int   nvalid = 0;
        int   nstall = 0;
        logic prev_v = 1'b0;
        idle_prefix();
        for (int k = 0; k < 400; k++) begin
            drive_cycle(1'b1, (k % 100) < 50);
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL square_50 cyc=%0d {v,st,p,h,l} got=%h exp=%h", cyc, obs(), mdl());
            end
            if (stalled === 1'b1) nstall++;
            if (meas_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (prev_v === 1'b1 || period !== CNT_W'(100) || high_time !== CNT_W'(50) ||
                    low_time !== CNT_W'(50)) begin
                    errors++;
                    $display("FAIL square_values got prev_v=%b p=%0d h=%0d l=%0d exp 0 100 50 50",
                             prev_v, period, high_time, low_time);
                end
            end
            prev_v = meas_valid;
        end
        checks++;
        if (nvalid != 3 || nstall != 0) begin
            errors++;
            $display("FAIL square_counts got valid=%0d stall_cycles=%0d exp 3 0", nvalid, nstall);
        end
    endtask

    task automatic test_stall();
        int   t_high = 0;
        int   t_rise2 = 0;
        int   t_stall = -1;
        int   t_clear = -1;
        int   nvalid = 0;
        int   k = 0;
        logic s;
        logic prev_st = 1'b0;
        idle_prefix();
        for (k = 0; k < 195; k++) begin
            s = (k < 130) || (k >= 140 && k < 160) || (k >= 180 && k < 185);
            drive_cycle(1'b1, s);
            if (k == 0) t_high = cyc;
            if (k == 140) t_rise2 = cyc;
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL stall cyc=%0d {v,st,p,h,l} got=%h exp=%h", cyc, obs(), mdl());
            end
            if (stalled === 1'b1 && prev_st === 1'b0 && t_stall < 0) begin
                t_stall = cyc;
                checks++;
                if (period !== CNT_W'(100) || high_time !== CNT_W'(50) || low_time !== CNT_W'(50)) begin
                    errors++;
                    $display("FAIL stall_hold got p=%0d h=%0d l=%0d exp 100 50 50", period, high_time, low_time);
                end
            end
            if (stalled === 1'b0 && prev_st === 1'b1) t_clear = cyc;
            if (meas_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (period !== CNT_W'(40) || high_time !== CNT_W'(20) || low_time !== CNT_W'(20)) begin
                    errors++;
                    $display("FAIL stall_recover got p=%0d h=%0d l=%0d exp 40 20 20", period, high_time, low_time);
                end
            end
            prev_st = stalled;
        end
        checks++;
        if (t_stall != t_high + 2 + TMO) begin
            errors++;
            $display("FAIL stall_time got %0d exp %0d", t_stall, t_high + 2 + TMO);
        end
        checks++;
        if (t_clear != t_rise2 + 2 || nvalid != 1) begin
            errors++;
            $display("FAIL stall_clear got clear=%0d valid=%0d exp %0d 1", t_clear, nvalid, t_rise2 + 2);
        end
    endtask

    // en low for three periods, raised again in the middle of a high phase
    task automatic test_en_drop();
        int   nv_pre = 0;
        int   nv_off = 0;
        int   nv_post = 0;
        logic e;
        idle_prefix();
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 20; k++) begin
                e = (p < 3) || (p > 6) || (p == 6 && k >= 5);
                drive_cycle(e, k < 10);
                checks++;
                if (obs() !== mdl()) begin
                    errors++;
                    $display("FAIL en_drop cyc=%0d {v,st,p,h,l} got=%h exp=%h", cyc, obs(), mdl());
                end
                if (meas_valid === 1'b1) begin
                    if (p < 3) nv_pre++;
                    else if (p < 6) nv_off++;
                    else nv_post++;
                end
                if (p == 5 && k == 19) begin
                    checks++;
                    if (period !== CNT_W'(20) || high_time !== CNT_W'(10) || low_time !== CNT_W'(10)) begin
                        errors++;
                        $display("FAIL en_hold got p=%0d h=%0d l=%0d exp 20 10 10", period, high_time, low_time);
                    end
                end
            end
        end
        checks++;
        if (nv_pre != 2 || nv_off != 0 || nv_post != 2) begin
            errors++;
            $display("FAIL en_counts got pre=%0d off=%0d post=%0d exp 2 0 2", nv_pre, nv_off, nv_post);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        idle_prefix();
        for (int k = 0; k < 15; k++) drive_cycle(1'b1, k < 10);
        #2 reset_n = 1'b0;
        sig_in = 1'b0;
        #1;
        checks++;
        if ({meas_valid, stalled, period, high_time, low_time} !== '0) begin
            errors++;
            $display("FAIL reset_mid_zero got v=%b s=%b p=%0d h=%0d l=%0d exp all 0",
                     meas_valid, stalled, period, high_time, low_time);
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 64; k++) begin
            drive_cycle(1'b1, k >= 4 && ((k - 4) % 20) < 10);
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d {v,st,p,h,l} got=%h exp=%h", cyc, obs(), mdl());
            end
            if (meas_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (period !== CNT_W'(20) || high_time !== CNT_W'(10) || low_time !== CNT_W'(10)) begin
                    errors++;
                    $display("FAIL reset_mid_values got p=%0d h=%0d l=%0d exp 20 10 10", period, high_time, low_time);
                end
            end
        end
        checks++;
        if (nvalid != 2) begin
            errors++;
            $display("FAIL reset_mid_count got %0d exp 2", nvalid);
        end
    endtask

    task automatic test_random();
        int   h;
        int   l;
        logic e;
        for (int p = 0; p < 40; p++) begin
            e = ($urandom_range(0, 7) != 0);
            h = $urandom_range(2, 110);
            l = $urandom_range(2, 60);
            for (int k = 0; k < h + l; k++) begin
                drive_cycle(e, k < h);
                checks++;
                if (obs() !== mdl()) begin
                    errors++;
                    $display("FAIL random p=%0d cyc=%0d {v,st,p,h,l} got=%h exp=%h", p, cyc, obs(), mdl());
                end
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_n = 1'b1;
        en      = 1'b0;
        sig_in  = 1'b0;
        model_reset();
        test_reset();
        test_pattern_3_2();
        test_square_50();
        test_stall();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
